// File: rtl/regfile_context_engine_pkg.sv
// Shared types for the register-file context save/restore engine.
package regfile_ctx_pkg;

    typedef enum logic {
        CtxSave    = 1'b0,
        CtxRestore = 1'b1
    } ctx_op_t;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSave     = 3'd1,
        StLoadReq  = 3'd2,
        StLoadWait = 3'd3,
        StDone     = 3'd4
    } ctx_state_t;

    localparam int WordBytes = 4;

endpackage

// File: rtl/regfile_context_engine_if.sv
// Bundle of the controller, register-file and data-memory signals seen by the engine.
interface regfile_context_engine_if #(
    parameter int DataWidth  = 32,
    parameter int IndexWidth = 5,
    parameter int AddrWidth  = 32
) ();

    logic                  start;
    logic                  op;
    logic [AddrWidth-1:0]  baseAddr;
    logic                  busy;
    logic                  done;

    logic [IndexWidth-1:0] rfReadAddr;
    logic [DataWidth-1:0]  rfReadData;
    logic                  rfWriteEn;
    logic [IndexWidth-1:0] rfWriteAddr;
    logic [DataWidth-1:0]  rfWriteData;

    logic                  memReq;
    logic                  memWe;
    logic [AddrWidth-1:0]  memAddr;
    logic [DataWidth-1:0]  memWData;
    logic                  memGnt;
    logic                  memRValid;
    logic [DataWidth-1:0]  memRData;

    modport master (
        input  start, op, baseAddr, rfReadData, memGnt, memRValid, memRData,
        output busy, done, rfReadAddr, rfWriteEn, rfWriteAddr, rfWriteData,
               memReq, memWe, memAddr, memWData
    );

    modport slave (
        output start, op, baseAddr, rfReadData, memGnt, memRValid, memRData,
        input  busy, done, rfReadAddr, rfWriteEn, rfWriteAddr, rfWriteData,
               memReq, memWe, memAddr, memWData
    );

endinterface

// File: rtl/regfile_context_engine.sv
// Saves or restores registers FirstReg..LastReg to/from a word-aligned memory area,
// one register per memory transaction. States: Idle -> Save | LoadReq<->LoadWait -> Done.
module regfile_context_engine
    import regfile_ctx_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int NumRegs    = 32,
    parameter int IndexWidth = $clog2(NumRegs),
    parameter int AddrWidth  = 32,
    parameter int FirstReg   = 1,
    parameter int LastReg    = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_context_engine_if.master bus
);

    localparam logic [IndexWidth-1:0] FirstIdx  = IndexWidth'(FirstReg);
    localparam logic [IndexWidth-1:0] LastIdx   = IndexWidth'(LastReg);
    localparam logic [IndexWidth-1:0] IdxOne    = IndexWidth'(1);
    localparam logic [AddrWidth-1:0]  AddrStep  = AddrWidth'(WordBytes);
    localparam logic [AddrWidth-1:0]  AlignMask = ~AddrWidth'(WordBytes - 1);
    localparam logic [DataWidth-1:0]  ZeroData  = '0;

    if (FirstReg < 1 || LastReg < FirstReg || LastReg >= NumRegs) begin : g_bad_range
        $error("regfile_context_engine: register range %0d..%0d invalid for %0d registers",
               FirstReg, LastReg, NumRegs);
    end

    ctx_state_t            state_q;
    logic [IndexWidth-1:0] idx_q;
    logic [AddrWidth-1:0]  addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic                  last_reg;
    logic                  wr_fire;

    assign last_reg = (idx_q == LastIdx);
    assign wr_fire  = (state_q == StLoadWait) && bus.memRValid;

    // addr_q tracks base + (idx - FirstReg) * WordBytes incrementally, wrapping silently.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        addr_q    <= bus.baseAddr & AlignMask;
                        idx_q     <= FirstIdx;
                        busy_q    <= 1'b1;
                        mem_req_q <= 1'b1;
                        if (ctx_op_t'(bus.op) == CtxSave) begin
                            state_q  <= StSave;
                            mem_we_q <= 1'b1;
                        end else begin
                            state_q  <= StLoadReq;
                            mem_we_q <= 1'b0;
                        end
                    end
                end
                StSave: begin
                    if (bus.memGnt) begin
                        if (last_reg) begin
                            state_q   <= StDone;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                        end else begin
                            idx_q  <= idx_q + IdxOne;
                            addr_q <= addr_q + AddrStep;
                        end
                    end
                end
                StLoadReq: begin
                    if (bus.memGnt) begin
                        state_q   <= StLoadWait;
                        mem_req_q <= 1'b0;
                    end
                end
                StLoadWait: begin
                    if (bus.memRValid) begin
                        if (last_reg) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= StLoadReq;
                            idx_q     <= idx_q + IdxOne;
                            addr_q    <= addr_q + AddrStep;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Store data and write-back are combinational so each transfer costs no extra cycle.
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.memReq      = mem_req_q;
    assign bus.memWe       = mem_we_q;
    assign bus.memAddr     = mem_req_q ? addr_q : '0;
    assign bus.rfReadAddr  = (state_q == StSave) ? idx_q : '0;
    assign bus.memWData    = (state_q == StSave) ? bus.rfReadData : ZeroData;
    assign bus.rfWriteEn   = wr_fire;
    assign bus.rfWriteAddr = wr_fire ? idx_q : '0;
    assign bus.rfWriteData = wr_fire ? bus.memRData : ZeroData;

endmodule

// File: tb/tb_regfile_context_engine.sv
// Randomized bench for regfile_context_engine with a transaction-level memory/regfile model.
module tb_regfile_context_engine;
    import regfile_ctx_pkg::*;

    localparam logic [31:0] RspKey = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          idx;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] rf    [32];
    logic [31:0] rf_wr [32];
    logic [31:0] mem   [logic [31:0]];
    logic [31:0] b_addr [3];
    ev_t  store_q[$];
    ev_t  load_q[$];
    ev_t  write_q[$];
    int   lat_seq[$];
    int   gnt_seq[$];
    int   t0, exp_done, done_seen, load_k, rsp_cnt;
    logic [31:0] rsp_addr;
    bit   win_a = 1'b0;
    bit   cur_restore = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_context_engine_if #(.DataWidth(32), .IndexWidth(5), .AddrWidth(32)) bus_a ();
    regfile_context_engine_if #(.DataWidth(32), .IndexWidth(5), .AddrWidth(32)) bus_b ();

    regfile_context_engine #(.FirstReg(1), .LastReg(31)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    regfile_context_engine #(.FirstReg(10), .LastReg(12)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    assign bus_a.rfReadData = rf[bus_a.rfReadAddr];
    assign bus_b.rfReadData = rf[bus_b.rfReadAddr];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic void clear_model();
        store_q.delete();
        load_q.delete();
        write_q.delete();
        lat_seq.delete();
        gnt_seq.delete();
    endfunction

    function automatic void prep_save(input logic [31:0] base, input int first, input int last);
        clear_model();
        for (int i = first; i <= last; i++)
            store_q.push_back('{addr: (base & ~32'h3) + 32'(4 * (i - first)), data: rf[i], idx: i});
    endfunction

    function automatic void prep_restore(input logic [31:0] base);
        logic [31:0] a;
        clear_model();
        for (int i = 1; i <= 31; i++) begin
            a = (base & ~32'h3) + 32'(4 * (i - 1));
            load_q.push_back('{addr: a, data: 32'h0, idx: i});
            write_q.push_back('{addr: a, data: a ^ RspKey, idx: i});
        end
    endfunction

    // Save completes the cycle after the grant of the last register.
    function automatic int save_done_cycle(input int n);
        int got = 0;
        for (int r = 1; r < 1000; r++) begin
            if (r >= gnt_seq.size() || gnt_seq[r] != 0) got++;
            if (got == n) return r + 1;
        end
        return 0;
    endfunction

    always @(negedge clk) begin : mon_a
        int rel;
        if (win_a) begin
            rel = cyc - t0;
            check("busy", 32'(bus_a.busy), 32'(rel > 0 && rel < exp_done));
            check("done", 32'(bus_a.done), 32'(rel == exp_done));
            if (bus_a.done) done_seen++;
            check("wr_en", 32'(bus_a.rfWriteEn), 32'(cur_restore && bus_a.memRValid));
            if (bus_a.memReq && bus_a.memWe) begin
                if (store_q.size() == 0) check("store_overrun", 32'(store_q.size()), 32'd1);
                else begin
                    check("st_addr", bus_a.memAddr, store_q[0].addr);
                    check("st_data", bus_a.memWData, store_q[0].data);
                    check("st_ridx", 32'(bus_a.rfReadAddr), 32'(store_q[0].idx));
                    if (bus_a.memGnt) begin
                        mem[bus_a.memAddr] = bus_a.memWData;
                        void'(store_q.pop_front());
                    end
                end
            end
            if (bus_a.memReq && !bus_a.memWe) begin
                if (load_q.size() == 0) check("load_overrun", 32'(load_q.size()), 32'd1);
                else begin
                    check("ld_addr", bus_a.memAddr, load_q[0].addr);
                    if (bus_a.memGnt) begin
                        void'(load_q.pop_front());
                        rsp_addr = bus_a.memAddr;
                        rsp_cnt  = (load_k < lat_seq.size()) ? lat_seq[load_k] : 1;
                        load_k++;
                    end
                end
            end
            if (bus_a.rfWriteEn) begin
                check("wr_nonzero", 32'(bus_a.rfWriteAddr != 5'd0), 32'd1);
                if (write_q.size() == 0) check("write_overrun", 32'(write_q.size()), 32'd1);
                else begin
                    check("wr_addr", 32'(bus_a.rfWriteAddr), 32'(write_q[0].idx));
                    check("wr_data", bus_a.rfWriteData, write_q[0].data);
                    rf_wr[bus_a.rfWriteAddr] = bus_a.rfWriteData;
                    void'(write_q.pop_front());
                end
            end
        end
    end

    task automatic run_a(input bit is_restore, input logic [31:0] base, input int dur,
                         input int extra1, input int extra2, input int stop_at);
        @(posedge clk); #1;
        exp_done    = dur;
        done_seen   = 0;
        load_k      = 0;
        rsp_cnt     = 0;
        cur_restore = is_restore;
        bus_a.op        = is_restore ? CtxRestore : CtxSave;
        bus_a.baseAddr  = base;
        bus_a.start     = 1'b1;
        bus_a.memGnt    = 1'b1;
        bus_a.memRValid = 1'b0;
        t0    = cyc;
        win_a = 1'b1;
        for (int r = 1; r <= stop_at; r++) begin
            @(posedge clk); #1;
            bus_a.start    = (r == extra1 || r == extra2);
            bus_a.op       = 1'($urandom_range(0, 1));
            bus_a.baseAddr = $urandom;
            bus_a.memGnt   = (r < gnt_seq.size()) ? (gnt_seq[r] != 0) : 1'b1;
            if (is_restore) begin
                bus_a.memRValid = 1'b0;
                bus_a.memRData  = $urandom;
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        bus_a.memRValid = 1'b1;
                        bus_a.memRData  = rsp_addr ^ RspKey;
                    end
                end
            end else begin
                bus_a.memRValid = 1'($urandom_range(0, 1));
                bus_a.memRData  = $urandom;
            end
        end
        @(negedge clk); #1;
    endtask

    task automatic finish_a(input string nm);
        win_a = 1'b0;
        bus_a.start     = 1'b0;
        bus_a.memRValid = 1'b0;
        check({nm, "_done_pulses"}, 32'(done_seen), 32'd1);
        check({nm, "_stores_left"}, 32'(store_q.size()), 32'd0);
        check({nm, "_loads_left"},  32'(load_q.size()), 32'd0);
        check({nm, "_writes_left"}, 32'(write_q.size()), 32'd0);
    endtask

    task automatic check_idle_a(input string nm);
        check({nm, "_busy"},   32'(bus_a.busy), 32'd0);
        check({nm, "_done"},   32'(bus_a.done), 32'd0);
        check({nm, "_req"},    32'(bus_a.memReq), 32'd0);
        check({nm, "_we"},     32'(bus_a.memWe), 32'd0);
        check({nm, "_wen"},    32'(bus_a.rfWriteEn), 32'd0);
        check({nm, "_maddr"},  bus_a.memAddr, 32'd0);
        check({nm, "_wdata"},  bus_a.memWData, 32'd0);
        check({nm, "_raddr"},  32'(bus_a.rfReadAddr), 32'd0);
        check({nm, "_waddr"},  32'(bus_a.rfWriteAddr), 32'd0);
        check({nm, "_wrdata"}, bus_a.rfWriteData, 32'd0);
    endtask

    initial begin
        int dur;
        logic [31:0] base;
        bus_a.start = 1'b0; bus_a.op = 1'b0; bus_a.baseAddr = '0;
        bus_a.memGnt = 1'b1; bus_a.memRValid = 1'b0; bus_a.memRData = '0;
        bus_b.start = 1'b0; bus_b.op = 1'b0; bus_b.baseAddr = '0;
        bus_b.memGnt = 1'b1; bus_b.memRValid = 1'b0; bus_b.memRData = '0;
        b_addr = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        for (int i = 0; i < 32; i++) begin
            rf[i]    = $urandom;
            rf_wr[i] = '0;
        end
        rf[0]  = '0;
        rf[5]  = 32'h1234_5678;
        rf[31] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_a("reset");
        check("reset_b_busy", 32'(bus_b.busy), 32'd0);
        check("reset_b_req",  32'(bus_b.memReq), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Save of x1..x31 to 0x1000 with grant always high.
        prep_save(32'h1000, 1, 31);
        run_a(1'b0, 32'h1000, 32, -1, -1, 35);
        finish_a("save");
        check("save_x5_mem",  mem[32'h1010], 32'h1234_5678);
        check("save_x31_mem", mem[32'h1078], 32'hDEAD_BEEF);

        // Restore from 0x2000, memory answers addr ^ 0xA5A50000 one cycle after grant.
        prep_restore(32'h2000);
        for (int i = 0; i < 31; i++) lat_seq.push_back(1);
        run_a(1'b1, 32'h2000, 63, -1, -1, 66);
        finish_a("restore");
        check("restore_x1",  rf_wr[1],  32'hA5A5_2000);
        check("restore_x31", rf_wr[31], 32'hA5A5_2078);

        // Grant withheld for three cycles while x7 is presented.
        prep_save(32'h1800, 1, 31);
        for (int r = 0; r < 40; r++) gnt_seq.push_back((r >= 7 && r <= 9) ? 0 : 1);
        run_a(1'b0, 32'h1800, 35, -1, -1, 38);
        finish_a("stall");

        // start pulsed mid-operation and in the done cycle.
        prep_save(32'h4000, 1, 31);
        run_a(1'b0, 32'h4000, 32, 5, 32, 36);
        finish_a("restart");

        for (int k = 0; k < 2; k++) begin
            base = $urandom;
            prep_save(base, 1, 31);
            gnt_seq.push_back(1);
            for (int r = 1; r < 150; r++) gnt_seq.push_back(($urandom_range(0, 3) != 0) ? 1 : 0);
            dur = save_done_cycle(31);
            run_a(1'b0, base, dur, $urandom_range(2, 20), -1, dur + 3);
            finish_a("rand_save");

            base = $urandom;
            prep_restore(base);
            dur = 1;
            for (int i = 0; i < 31; i++) begin
                lat_seq.push_back($urandom_range(1, 3));
                dur += 1 + lat_seq[i];
            end
            run_a(1'b1, base, dur, $urandom_range(2, 20), -1, dur + 3);
            finish_a("rand_restore");
        end

        // Reset while waiting on the load for x10; its data then arrives after reset.
        for (int i = 0; i < 32; i++) rf_wr[i] = '0;
        prep_restore(32'h3000);
        for (int i = 0; i < 31; i++) lat_seq.push_back((i == 9) ? 1000 : 1);
        run_a(1'b1, 32'h3000, 63, -1, -1, 20);
        win_a = 1'b0;
        check("rst_pre_busy", 32'(bus_a.busy), 32'd1);
        check("rst_pre_req",  32'(bus_a.memReq), 32'd0);
        check("rst_pre_writes_left", 32'(write_q.size()), 32'd22);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        bus_a.memRValid = 1'b1;
        bus_a.memRData  = 32'h5555_AAAA;
        @(negedge clk);
        check_idle_a("rst_late");
        @(posedge clk); #1;
        bus_a.memRValid = 1'b0;
        @(negedge clk);
        check_idle_a("rst_after");
        check("rst_x10_untouched", rf_wr[10], 32'd0);
        rsp_cnt = 0;
        clear_model();

        // Narrow range x10..x12 with an area that wraps past the top of memory.
        @(posedge clk); #1;
        bus_b.baseAddr = 32'hFFFF_FFFC;
        bus_b.op       = CtxSave;
        bus_b.start    = 1'b1;
        for (int r = 0; r <= 6; r++) begin
            @(negedge clk);
            check("b_done", 32'(bus_b.done), 32'(r == 4));
            check("b_busy", 32'(bus_b.busy), 32'(r >= 1 && r <= 3));
            if (r >= 1 && r <= 3) begin
                check("b_req",  32'(bus_b.memReq), 32'd1);
                check("b_we",   32'(bus_b.memWe), 32'd1);
                check("b_addr", bus_b.memAddr, b_addr[r-1]);
                check("b_data", bus_b.memWData, rf[9+r]);
            end
            @(posedge clk); #1;
            bus_b.start = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
